// File: rtl/rf_pkg.sv
// Shared types for the register-file write path: address/data widths and the
// write-request record carried from requesters to the write port.
package rf_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    localparam rf_addr_t REG_ZERO = '0;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational NREQ-way round-robin search starting at ptr_i.
// Produces a one-hot grant plus the granted index; no state of its own.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_i) + k) % NREQ;
            if (!found && req_i[PTR_W'(cand)]) begin
                found                = 1'b1;
                gnt_o[PTR_W'(cand)]  = 1'b1;
                idx_o                = PTR_W'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin share of the register-file write port among NREQ writeback units.
// The winner is registered for one cycle; writes to register 0 are swallowed.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned ADDR  = ADDR_W,
    parameter int unsigned BUS_W = DATA_W,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  reloj,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*BUS_W-1:0] req_data,
    input  logic                  stall,
    output logic [NREQ-1:0]       gnt,
    output logic                  rd_we,
    output logic [ADDR-1:0]       rd_addr,
    output logic [BUS_W-1:0]      rd_w_data,
    output logic                  busy
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rd_we_q, rd_we_d;
    logic [ADDR-1:0]  rd_addr_q, rd_addr_d;
    logic [BUS_W-1:0] rd_data_q, rd_data_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [NREQ-1:0]  req_elig;
    logic [NREQ-1:0]  arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;
    logic [ADDR-1:0]  win_addr;
    logic [BUS_W-1:0] win_data;
    logic             win_zero;

    // Masking the arbiter input keeps gnt low during stall and while in reset.
    assign req_elig = (stall || !reset) ? '0 : req;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_elig),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign win_addr = req_addr[32'(arb_idx)*ADDR +: ADDR];
    assign win_data = req_data[32'(arb_idx)*BUS_W +: BUS_W];
    assign win_zero = (win_addr == ADDR'(REG_ZERO));

    always_comb begin
        ptr_d      = ptr_q;
        rd_we_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        drop_cnt_d = drop_cnt_q;
        if (arb_valid) begin
            ptr_d     = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + PTR_W'(1);
            rd_we_d   = !win_zero;
            rd_addr_d = win_addr;
            rd_data_d = win_data;
            if (win_zero && drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign gnt       = arb_gnt;
    assign busy      = (|req) && !(|arb_gnt);
    assign rd_we     = rd_we_q;
    assign rd_addr   = rd_addr_q;
    assign rd_w_data = rd_data_q;

    gnt_onehot: assert property (@(posedge reloj) disable iff (!reset) $onehot0(gnt));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Table-driven bench for rf_write_arbiter with a write-port scoreboard,
// plus hand sequences for register-0 saturation and mid-operation reset.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic         reloj = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic         stall;
    logic [3:0]   gnt;
    logic         rd_we;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_w_data;
    logic         busy;

    rf_write_arbiter #(
        .ADDR  (5),
        .BUS_W (32),
        .NREQ  (4)
    ) dut (
        .reloj     (reloj),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .stall     (stall),
        .gnt       (gnt),
        .rd_we     (rd_we),
        .rd_addr   (rd_addr),
        .rd_w_data (rd_w_data),
        .busy      (busy)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        logic [3:0]   req;
        logic         stall;
        logic [19:0]  addrs;
        logic [127:0] datas;
        logic [3:0]   gnt;
        logic         busy;
    } vec_t;

    typedef struct packed {
        logic    we;
        wr_req_t w;
    } exp_wr_t;

    exp_wr_t     sb[$];
    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  m_ptr   = '0;
    rf_addr_t    m_addr  = '0;
    rf_data_t    m_data  = '0;
    int unsigned m_drop  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] r, input logic s, input logic [19:0] a,
                                 input logic [31:0] seed, input logic [3:0] g, input logic b);
        vec_t v;
        v.req   = r;
        v.stall = s;
        v.addrs = a;
        v.datas = {seed + 32'd3, seed + 32'd2, seed + 32'd1, seed};
        v.gnt   = g;
        v.busy  = b;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic apply(input vec_t v);
        exp_wr_t e;
        e        = '0;
        req      = v.req;
        stall    = v.stall;
        req_addr = v.addrs;
        req_data = v.datas;
        #2;
        chk("gnt", 64'(gnt), 64'(v.gnt));
        chk("busy", 64'(busy), 64'(v.busy));
        for (int i = 0; i < 4; i++) begin
            if (v.gnt[i]) begin
                m_addr = v.addrs[i*5 +: 5];
                m_data = v.datas[i*32 +: 32];
                m_ptr  = 2'(i + 1);
                e.we   = (m_addr != 5'd0);
                if (m_addr == 5'd0 && m_drop < 255) m_drop++;
            end
        end
        e.w.addr = m_addr;
        e.w.data = m_data;
        sb.push_back(e);
        @(posedge reloj);
        #1;
        e = sb.pop_front();
        chk("rd_we", 64'(rd_we), 64'(e.we));
        chk("rd_addr", 64'(rd_addr), 64'(e.w.addr));
        chk("rd_w_data", 64'(rd_w_data), 64'(e.w.data));
        chk("ptr", 64'(dut.ptr_q), 64'(m_ptr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        req      = 4'hF;
        stall    = 1'b0;
        req_addr = '0;
        req_data = '0;
        repeat (3) @(posedge reloj);
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h1);
        chk("rst_rd_we", 64'(rd_we), 64'h0);
        chk("rst_rd_addr", 64'(rd_addr), 64'h0);
        chk("rst_rd_data", 64'(rd_w_data), 64'h0);
        chk("rst_ptr", 64'(dut.ptr_q), 64'h0);
        chk("rst_drop", 64'(dut.drop_cnt_q), 64'h0);
        req = 4'h0;
        @(negedge reloj);
        reset = 1'b1;
        @(posedge reloj);
        #1;

        for (int i = 0; i < 5; i++) vecs.push_back(mkv(4'b0000, 1'b0, 20'd0, 32'h0, 4'b0000, 1'b0));
        vecs.push_back(mkv(4'b0100, 1'b0, {5'd0, 5'd7, 5'd0, 5'd0}, 32'hDEADBEED, 4'b0100, 1'b0));
        vecs.push_back(mkv(4'b1000, 1'b0, {5'd9, 15'd0}, 32'h100, 4'b1000, 1'b0));
        vecs.push_back(mkv(4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32'hA000, 4'b0001, 1'b0));
        vecs.push_back(mkv(4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32'hA000, 4'b0010, 1'b0));
        vecs.push_back(mkv(4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32'hA000, 4'b0100, 1'b0));
        vecs.push_back(mkv(4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32'hA000, 4'b1000, 1'b0));
        vecs.push_back(mkv(4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32'hA000, 4'b0001, 1'b0));
        vecs.push_back(mkv(4'b0001, 1'b0, 20'd0, 32'h12345678, 4'b0001, 1'b0));
        vecs.push_back(mkv(4'b1000, 1'b0, {5'd31, 15'd0}, 32'hB0, 4'b1000, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(4'b0011, 1'b1, {10'd0, 5'd12, 5'd11}, 32'hC0, 4'b0000, 1'b1));
        vecs.push_back(mkv(4'b0011, 1'b0, {10'd0, 5'd12, 5'd11}, 32'hC0, 4'b0001, 1'b0));
        vecs.push_back(mkv(4'b0010, 1'b0, {10'd0, 5'd12, 5'd11}, 32'hC0, 4'b0010, 1'b0));
        vecs.push_back(mkv(4'b0101, 1'b0, {5'd0, 5'd10, 5'd0, 5'd10}, 32'hD0, 4'b0100, 1'b0));
        vecs.push_back(mkv(4'b0001, 1'b0, {15'd0, 5'd10}, 32'hD0, 4'b0001, 1'b0));
        vecs.push_back(mkv(4'b0000, 1'b0, 20'd0, 32'h0, 4'b0000, 1'b0));
        vecs.push_back(mkv(4'b0000, 1'b1, 20'd0, 32'h0, 4'b0000, 1'b0));

        foreach (vecs[i]) apply(vecs[i]);
        chk("drop_cnt_1", 64'(dut.drop_cnt_q), 64'd1);

        for (int i = 0; i < 260; i++) apply(mkv(4'b0001, 1'b0, 20'd0, 32'hE0, 4'b0001, 1'b0));
        chk("drop_cnt_sat", 64'(dut.drop_cnt_q), 64'd255);
        chk("drop_cnt_model", 64'(m_drop), 64'd255);

        // Mid-operation reset: a registered write is killed asynchronously.
        req      = 4'b0010;
        stall    = 1'b0;
        req_addr = {10'd0, 5'd5, 5'd0};
        req_data = {64'd0, 32'hCAFE0001, 32'd0};
        #2;
        chk("mr_gnt", 64'(gnt), 64'b0010);
        @(posedge reloj);
        #1;
        chk("mr_rd_we_pre", 64'(rd_we), 64'h1);
        chk("mr_rd_addr_pre", 64'(rd_addr), 64'd5);
        chk("mr_ptr_pre", 64'(dut.ptr_q), 64'd2);
        @(negedge reloj);
        reset = 1'b0;
        #1;
        chk("mr_rd_we", 64'(rd_we), 64'h0);
        chk("mr_rd_addr", 64'(rd_addr), 64'h0);
        chk("mr_ptr", 64'(dut.ptr_q), 64'h0);
        chk("mr_gnt_rst", 64'(gnt), 64'h0);
        chk("mr_drop", 64'(dut.drop_cnt_q), 64'h0);
        req = 4'b0000;
        @(negedge reloj);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge reloj);
            #1;
            chk("mr_idle_we", 64'(rd_we), 64'h0);
            chk("mr_idle_ptr", 64'(dut.ptr_q), 64'h0);
        end

        m_ptr  = '0;
        m_addr = '0;
        m_data = '0;
        m_drop = 0;
        apply(mkv(4'b0100, 1'b0, {5'd0, 5'd3, 10'd0}, 32'hF0, 4'b0100, 1'b0));
        apply(mkv(4'b0000, 1'b0, 20'd0, 32'h0, 4'b0000, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of `register_file` (`rd_addr` / `rd_w_data`, plus a write strobe) between NREQ independent writeback requesters, e.g. ALU, load unit, multiplier.
- Round-robin arbitration grants at most one write per cycle.
- The winning write is registered and presented to `register_file` on the next cycle.
- Writes to register 0 are accepted but suppressed, since register 0 is hardwired zero.

Parameters:
- ADDR, 5, register address width (32 registers).
- BUS_W, 32, register data width.
- NREQ, 4, number of write requesters (2..8).

Ports:
- reloj  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester write request; held until granted.
- req_addr  input  NREQ*ADDR  flattened destination addresses; requester i occupies bits [i*ADDR +: ADDR].
- req_data  input  NREQ*BUS_W  flattened write data; requester i occupies bits [i*BUS_W +: BUS_W].
- stall  input  1  when high, no grant is issued.
- gnt  output  NREQ  one-hot grant, combinational.
- rd_we  output  1  registered write strobe to `register_file`.
- rd_addr  output  ADDR  registered write address.
- rd_w_data  output  BUS_W  registered write data.
- busy  output  1  high when any req bit is high and no grant issued this cycle.

Behaviour:
- Reset (reset low, asynchronous): ptr=0, rd_we=0, rd_addr=0, rd_w_data=0, drop_cnt=0. gnt is all zeros while reset is low.
- Priority pointer ptr (width clog2(NREQ)) names the highest-priority requester.
- Grant search, combinational: scan indices ptr, ptr+1, …, ptr+NREQ-1 mod NREQ. The first index with req high gets gnt. gnt=0 if stall=1 or req=0.
- Handshake: a transaction completes on the rising edge where req[i] & gnt[i].
  - Requester i must hold req_addr/req_data stable while req[i] is high and not granted.
  - The requester may present a new transaction immediately in the next cycle.
- Pointer update on a completed grant to i: ptr <= (i+1) mod NREQ. No grant: ptr holds.
- Guarantee: a held request is granted within NREQ non-stalled cycles (no starvation).
- Write port, one cycle latency after grant:
  - rd_we <= 1 iff a grant completed and the granted address != 0.
  - rd_addr <= granted address; rd_w_data <= granted data.
  - When no grant occurs, rd_we <= 0 and rd_addr/rd_w_data hold their previous values.
- Register 0: the grant is still issued and the requester is released; rd_we stays 0. Internal debug counter drop_cnt (8-bit, saturating at 255) increments.
- Back-to-back: one write per cycle sustained. Consecutive grants to different requesters produce consecutive rd_we pulses.
- Same destination address from two requesters in the same cycle: the round-robin winner goes first and the loser follows next cycle. The loser's value is therefore final in the register file. No merging.
- stall:
  - Rising stall blocks the grant in that same cycle.
  - A write registered in the previous cycle still appears; stall does not cancel it.
  - ptr is frozen during stall.
- busy = |req & ~|gnt.
- Reset asserted mid-operation: the pending registered write is dropped (rd_we forced 0 asynchronously). Requesters must re-request after release.
- Only one grant bit is ever high (one-hot or zero); assertion included in RTL.

Decomposition:
- Package rf_pkg:
  - localparams ADDR_W=5, DATA_W=32, REG_ZERO='0.
  - typedef rf_addr_t (logic [ADDR_W-1:0]).
  - typedef rf_data_t (logic [DATA_W-1:0]).
  - typedef wr_req_t, a struct with addr and data fields.
- One sub-module, rr_arbiter:
  - Pure NREQ-way round-robin: req, ptr in; one-hot gnt and granted index out.
  - Reusable for the read ports later.
- Top-level rf_write_arbiter holds: ptr register, write-port registers, register-0 filter, drop counter.

Test Plan:
- Reset release, req=4'b0000 for 5 cycles -> gnt=0, rd_we=0, rd_addr=0, rd_w_data=0, busy=0.
- Single requester: req=4'b0100, addr=7, data=32'hDEADBEEF -> gnt=4'b0100 same cycle; next cycle rd_we=1, rd_addr=7, rd_w_data=32'hDEADBEEF; ptr=3.
- Fairness: all four req held high from ptr=0, addr=i+1 -> grants 0,1,2,3,0 in successive cycles; rd_we high 5 consecutive cycles with rd_addr 1,2,3,4,1.
- Register 0: req=4'b0001, addr=0, data=32'h12345678 -> gnt=4'b0001; next cycle rd_we=0; drop_cnt=1; ptr=1.
- stall: req=4'b0011 with stall=1 for 3 cycles -> gnt=0, busy=1, ptr unchanged; stall=0 -> gnt=4'b0001, then 4'b0010.
- Mid-operation reset: grant completes at edge N, reset low half a cycle later -> rd_we=0 immediately, ptr=0; after release no spurious write occurs.
